// File: rtl/mul_div_pkg.sv
// Shared encodings for the integer execute stage: ALU control codes,
// M-extension operation codes (RISC-V funct3) and the mul_div FSM states.
package mul_div_pkg;

  // ALU control codes used by the integer ALU
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_t;

  // M-extension operation select, equal to the instruction funct3
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  // mul_div control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // Divide family: funct3[2] set
  function automatic logic op_is_div(input md_op_t op);
    return op[2];
  endfunction

  // Remainder family: REM and REMU
  function automatic logic op_is_rem(input md_op_t op);
    return op[2] & op[1];
  endfunction

  // First operand is two's complement for MUL, MULH, MULHSU, DIV, REM
  function automatic logic op1_signed(input md_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Second operand is two's complement for MUL, MULH, DIV, REM
  function automatic logic op2_signed(input md_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

endpackage

// File: rtl/mul_div_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per
// step. The dividend shifts out of the top of quo_q while quotient bits
// shift in at the bottom, so after XLEN steps quo_q is the quotient.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;

  // Trial subtraction: the true difference always lies in
  // [-2^XLEN, 2^XLEN), so bit XLEN is a reliable sign.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = ~diff[XLEN];
  end

  // Load operands on acceptance, then one restoring step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= {quo_q[XLEN-2:0], fits};
      rem_q <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mul_div.sv
// Iterative RISC-V M-extension multiply/divide unit. Operands are latched
// on acceptance, magnitudes are iterated for XLEN cycles and the sign is
// fixed up while the result is presented in DONE. Divide by zero and signed
// overflow skip the iteration and finish the cycle after acceptance.
module mul_div
  import mul_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  md_state_t         state, state_nxt;
  md_op_t            op_in, op_q;
  logic [XLEN-1:0]   op1_q, op2_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              special_in;
  logic [XLEN-1:0]   mag1_in, mag2_in;
  logic [XLEN:0]     add_sum;
  logic [XLEN-1:0]   quo_mag, rem_mag;

  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   final_res;

  assign op_in     = md_op_t'(op);
  assign state_dbg = state;

  // Acceptance, special-case detection and operand magnitudes at start
  always_comb begin
    accept     = (state == ST_IDLE) & start & ~flush;
    special_in = op_is_div(op_in) &
                 ((op2 == '0) |
                  (op1_signed(op_in) & (op1 == MOST_NEG) & (op2 == ALL_ONES)));
    mag1_in    = (op1_signed(op_in) & op1[XLEN-1]) ? -op1 : op1;
    mag2_in    = (op2_signed(op_in) & op2[XLEN-1]) ? -op2 : op2;
  end

  // Shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (product LSB) is set, then shift right by one
  always_comb begin
    add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
              (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  end

  // Operand latches, multiplier datapath and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MUL;
      op1_q   <= '0;
      op2_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      op1_q   <= op1;
      op2_q   <= op2;
      mcand_q <= mag1_in;
      prod_q  <= {{XLEN{1'b0}}, mag2_in};
      cnt_q   <= '0;
    end else if (state == ST_CALC) begin
      prod_q  <= {add_sum, prod_q[XLEN-1:1]};
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state == ST_CALC),
    .dividend  (mag1_in),
    .divisor   (mag2_in),
    .quotient  (quo_mag),
    .remainder (rem_mag)
  );

  // Sign fix-up and special-case selection of the final result
  always_comb begin
    a_neg    = op1_signed(op_q) & op1_q[XLEN-1];
    b_neg    = op2_signed(op_q) & op2_q[XLEN-1];
    prod_fix = (a_neg ^ b_neg) ? -prod_q : prod_q;
    quo_fix  = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem_fix  = a_neg ? -rem_mag : rem_mag;
    final_res = '0;
    if (op_is_div(op_q)) begin
      if (op2_q == '0) begin
        final_res = op_is_rem(op_q) ? op1_q : ALL_ONES;
      end else if (op1_signed(op_q) & (op1_q == MOST_NEG) & (op2_q == ALL_ONES)) begin
        final_res = op_is_rem(op_q) ? '0 : op1_q;
      end else begin
        final_res = op_is_rem(op_q) ? rem_fix : quo_fix;
      end
    end else if (op_q == OP_MUL) begin
      final_res = prod_fix[XLEN-1:0];
    end else begin
      final_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush aborts from any state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = special_in ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == CNT_W'(XLEN-1)) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs: busy covers CALC and DONE; done is cancelled by flush or rst
  always_comb begin
    busy   = (state != ST_IDLE);
    done   = (state == ST_DONE) & ~flush & ~rst;
    result = done ? final_res : result_q;
  end

  // Result holding register, updated only on a delivered done
  always_ff @(posedge clk) begin
    if (rst)       result_q <= '0;
    else if (done) result_q <= final_res;
  end

endmodule

// File: tb/tb_mul_div.sv
// Directed bench for mul_div (XLEN=32): inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_mul_div;
  import mul_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res = 32'h0;

  mul_div #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call right after tick(): drives start in this cycle (t), waits for done,
  // checks latency, busy through t+1..done, and the result. poke_at > 0
  // pulses a second start carrying different operands at cycle t+poke_at.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int poke_at);
    int   k;
    logic seen;
    logic busy_all;
    start = 1'b1;
    op    = o;
    op1   = a;
    op2   = b;
    @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'h0);
    check({tag, "_hold"}, result, last_res);
    k        = 0;
    seen     = 1'b0;
    busy_all = 1'b1;
    while (!seen && k < 100) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
      if (k == poke_at) begin
        start = 1'b1;
        op    = OP_MUL;
        op1   = 32'd7;
        op2   = 32'hFFFF_FFFD;
      end
      @(negedge clk);
      if (busy !== 1'b1) busy_all = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_all), 32'h1);
    check({tag, "_res"}, result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    int done_seen;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
    op1   = 32'h0;
    op2   = 32'h0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst = 1'b0;

    // Multiply: low half and the three high-half flavours
    tick(); run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    tick();
    @(negedge clk);
    check("mul_after_busy", 32'(busy), 32'h0);
    check("mul_after_done", 32'(done), 32'h0);
    check("mul_after_res", result, 32'hFFFF_FFEB);
    tick(); run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    tick(); run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    tick(); run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, 0);

    // Divide and remainder, signed and unsigned
    tick(); run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    tick(); run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    tick(); run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    tick(); run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    tick(); run_op("div_pos_neg", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 0);
    tick(); run_op("rem_pos_neg", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 0);

    // Divide by zero and signed overflow finish one cycle after acceptance
    tick(); run_op("divu_z", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    tick(); run_op("remu_z", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
    tick(); run_op("div_z", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, 0);
    tick(); run_op("rem_z", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
    tick(); run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    tick(); run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

    // Flush at t+10 of a DIV: no done, idle at t+11, start at t+11 accepted
    tick();
    start = 1'b1; op = OP_DIV; op1 = 32'hFFFF_FFF9; op2 = 32'd2;
    done_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      start = 1'b0;
      if (i == 10) flush = 1'b1;
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    tick();
    flush = 1'b0;
    check("flush_no_done", 32'(done_seen), 32'h0);
    run_op("after_flush", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);

    // Reset at t+5 of a DIVU: operation dropped, result cleared, no done
    tick();
    start = 1'b1; op = OP_DIVU; op1 = 32'd100; op2 = 32'd7;
    done_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      start = 1'b0;
      if (i == 5) rst = 1'b1;
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
    for (int i = 0; i < 40; i++) begin
      tick();
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("rst_mid_no_done", 32'(done_seen), 32'h0);
    last_res = 32'h0;

    // Start pulsed at t+3 with other operands is ignored
    tick(); run_op("poke_busy", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 3);
    // Start held in the done cycle is ignored; next cycle start is accepted
    tick(); run_op("poke_done", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33);
    tick(); run_op("after_poke", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
